// File: rtl/bpu_pkg.sv
// ---------------------------------------------------------------------------
// bpu_pkg
//
// Shared types for the branch prediction unit. ubtb_update_t is one pending
// write into the micro-BTB: the PC of the jump source (used as the uBTB
// index/tag) and the jump target.
//
// `MXLEN sets the machine address width. It defaults to 32 when no other
// file has defined it.
// ---------------------------------------------------------------------------
`ifndef MXLEN
`define MXLEN 32
`endif

package bpu_pkg;

    // One queued uBTB write: source PC and jump target.
    typedef struct packed {
        logic [`MXLEN-1:0] src;
        logic [`MXLEN-1:0] dst;
    } ubtb_update_t;

endpackage

// File: rtl/ubtb_update_queue.sv
// ---------------------------------------------------------------------------
// ubtb_update_queue
//
// Decouples backend branch resolution from the micro-BTB write port. Taken
// resolves are buffered in a circular FIFO and drained into the uBTB
// whenever its write port is free. Not-taken resolves are accepted but not
// stored, because the uBTB only records taken jumps.
//
// Parameters
//   DEPTH             number of queued updates (power of 2, >= 2)
//
// Ports
//   i_clk             clock, all state changes on the rising edge
//   i_rst             synchronous active-high reset
//   i_resolve_valid   backend presents a resolved control-flow instruction
//   o_resolve_ready   queue accepts the resolve this cycle
//   i_resolve_taken   the resolved instruction jumped
//   i_resolve_src     PC of the jump source
//   i_resolve_dst     jump target
//   i_flush           discard all pending updates
//   i_ubtb_ready      uBTB write port is free this cycle
//   o_ubtb_update     write strobe to the uBTB (head pops on the same edge)
//   o_pc_jumpsrc      write source PC (uBTB index/tag), 0 when empty
//   o_pc_jumpdst      write target, 0 when empty
//   o_count           number of valid entries
//   o_full, o_empty   queue status
//
// Build option
//   UBTB_UPDQ_COALESCE_EN  when defined, a taken resolve whose source PC
//                          already sits in the queue overwrites that entry's
//                          target rather than taking a new slot.
// ---------------------------------------------------------------------------
`ifndef MXLEN
`define MXLEN 32
`endif

module ubtb_update_queue
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_resolve_valid,
    output logic                         o_resolve_ready,
    input  logic                         i_resolve_taken,
    input  logic [`MXLEN-1:0]            i_resolve_src,
    input  logic [`MXLEN-1:0]            i_resolve_dst,
    input  logic                         i_flush,
    input  logic                         i_ubtb_ready,
    output logic                         o_ubtb_update,
    output logic [`MXLEN-1:0]            o_pc_jumpsrc,
    output logic [`MXLEN-1:0]            o_pc_jumpdst,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Entry storage is never reset; the pointers alone define which slots
    // hold live data.
    ubtb_update_t     mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits coincide.
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    logic             accept;
    logic             push;
    logic             pop;
    ubtb_update_t     head;

    assign rd_idx  = rd_ptr[IDX_W-1:0];
    assign wr_idx  = wr_ptr[IDX_W-1:0];

    // The pointer difference modulo 2*DEPTH is the occupancy, 0..DEPTH.
    assign o_count = wr_ptr - rd_ptr;
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    // Ready deliberately ignores i_ubtb_ready: a full queue stays closed for
    // the cycle even if the head drains, which keeps the backend handshake
    // free of any path from the uBTB side.
    assign o_resolve_ready = ~o_full & ~i_flush;
    assign accept          = i_resolve_valid & o_resolve_ready;

    assign pop             = ~o_empty & i_ubtb_ready & ~i_flush;
    assign o_ubtb_update   = pop;

    assign head            = mem[rd_idx];
    assign o_pc_jumpsrc    = o_empty ? '0 : head.src;
    assign o_pc_jumpdst    = o_empty ? '0 : head.dst;

`ifdef UBTB_UPDQ_COALESCE_EN
    logic             hit;
    logic [IDX_W-1:0] hit_idx;

    // Walk the live entries from oldest to youngest looking for the same
    // source PC. Later matches override earlier ones so the youngest entry
    // wins. The head is skipped while it pops, since it is leaving the
    // queue this edge and a write to it would be lost; in that case the
    // resolve enqueues normally.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PTR_W'(k) < o_count) && !(pop && (k == 0)) &&
                (mem[rd_idx + IDX_W'(k)].src == i_resolve_src)) begin
                hit     = 1'b1;
                hit_idx = rd_idx + IDX_W'(k);
            end
        end
    end

    assign push = accept & i_resolve_taken & ~hit;
`else
    assign push = accept & i_resolve_taken;
`endif

    // Storage writes: a new entry at the tail, or (when coalescing) a target
    // refresh of an existing entry. The two never happen in the same cycle.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_idx] <= '{src: i_resolve_src, dst: i_resolve_dst};
        end
`ifdef UBTB_UPDQ_COALESCE_EN
        if (accept && i_resolve_taken && hit) begin
            mem[hit_idx].dst <= i_resolve_dst;
        end
`endif
    end

    // Pointer update. Reset and flush both empty the queue by zeroing the
    // pointers; any stored entries are simply abandoned. Pointers wrap
    // naturally at 2*DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule
